clock_divider_bank: RTL

//  Multi-channel programmable clock divider. Successor to the fixed single-channel slow-clock generator.

---
 rtl/clock_divider_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with per-channel tick pulses.
// Half-period changes on a running channel are staged and applied only at a wrap, so no half-period is ever cut short or stretched.
module clock_divider_bank #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 28,
  parameter int DEFAULT_HALF = 250_000_000,
  parameter int RESET_EN     = 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_half,
  input  logic              i_cfg_en,
  input  logic              i_sync_restart,
  output logic [NUM_CH-1:0] o_div_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic             DEF_EN   = (RESET_EN != 0);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_half   [NUM_CH];
  logic [CNT_W-1:0]  r_staged [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_div;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_pending;

  logic              w_ch_ok;
  logic [NUM_CH-1:0] w_acc;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_wrap;
  logic [CNT_W-1:0]  w_hm1 [NUM_CH];

  // Handshake: a write transfers when i_cfg_valid & o_cfg_ready. Ready is
  // combinational, low only while the addressed channel holds a staged value;
  // out-of-range channels are always ready and their writes are dropped.
  always_comb begin
    w_ch_ok     = ({1'b0, i_cfg_ch} < NUM_CH_L);
    o_cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_cfg_ch == CH_W'(i)) o_cfg_ready = ~r_pending[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_acc[i]  = i_cfg_valid & w_ch_ok & ~r_pending[i] & (i_cfg_ch == CH_W'(i));
      w_run[i]  = r_en[i] & (r_half[i] != '0);
      w_hm1[i]  = (r_half[i] != '0) ? (r_half[i] - 1'b1) : '0;
      w_wrap[i] = w_run[i] & (r_cnt[i] == w_hm1[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_half[i]   <= DEF_HALF;
        r_staged[i] <= '0;
      end
      r_en      <= {NUM_CH{DEF_EN}};
      r_div     <= '0;
      r_tick    <= '0;
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_sync_restart) begin
          r_cnt[i]     <= '0;
          r_div[i]     <= 1'b0;
          r_tick[i]    <= 1'b0;
          r_pending[i] <= 1'b0;
          if (w_acc[i]) begin
            r_en[i]   <= i_cfg_en;
            r_half[i] <= i_cfg_half;
          end else if (r_pending[i]) begin
            r_half[i] <= r_staged[i];
          end
        end else if (w_acc[i] && (!w_run[i] || !i_cfg_en)) begin
          // Idle channel, or the write disables it: load directly, restart from zero.
          r_en[i]   <= i_cfg_en;
          r_half[i] <= i_cfg_half;
          r_cnt[i]  <= '0;
          r_div[i]  <= 1'b0;
          r_tick[i] <= 1'b0;
        end else begin
          if (w_acc[i] && !w_wrap[i]) begin
            r_staged[i]  <= i_cfg_half;
            r_pending[i] <= 1'b1;
          end
          if (w_wrap[i]) begin
            r_cnt[i]  <= '0;
            r_div[i]  <= ~r_div[i];
            r_tick[i] <= ~r_div[i];
            if (w_acc[i]) begin
              r_half[i] <= i_cfg_half;
            end else if (r_pending[i]) begin
              r_half[i]    <= r_staged[i];
              r_pending[i] <= 1'b0;
            end
          end else if (w_run[i]) begin
            r_cnt[i]  <= r_cnt[i] + 1'b1;
            r_tick[i] <= 1'b0;
          end else begin
            r_cnt[i]  <= '0;
            r_div[i]  <= 1'b0;
            r_tick[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_div_clk = r_div;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule
